// File: rtl/sram_like_arbiter.sv
// Two-requester (fetch / MEM-stage data) arbiter onto one sram-like port, one transaction in flight.
// Optional macro ARB_RR_EN: round-robin on simultaneous requests instead of fixed data-over-inst priority.
module sram_like_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              resetn,

    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,
    output logic [DATA_W-1:0] inst_rdata,

    input  logic              data_req,
    input  logic              data_wr,
    input  logic [1:0]        data_size,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic [DATA_W-1:0] data_rdata,

    output logic              req,
    output logic              wr,
    output logic [1:0]        size,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] wdata,
    input  logic              addr_ok,
    input  logic              data_ok,
    input  logic [DATA_W-1:0] rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic              owner, owner_nxt;   // 0 = inst, 1 = data
    logic              req_q, req_nxt;
    logic              wr_q, wr_nxt;
    logic [1:0]        size_q, size_nxt;
    logic [ADDR_W-1:0] addr_q, addr_nxt;
    logic [DATA_W-1:0] wdata_q, wdata_nxt;
    logic              grant_data;
    logic              addr_hit;
    logic              done_hit;

`ifdef ARB_RR_EN
    logic              last_grant, last_grant_nxt;

    // last_grant uses the owner encoding; reset value 0 makes data win the first conflict
    always_comb begin
        grant_data = (inst_req && data_req) ? ~last_grant : data_req;
    end
`else
    always_comb begin
        grant_data = data_req;
    end
`endif

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state   <= IDLE;
            owner   <= 1'b0;
            req_q   <= 1'b0;
            wr_q    <= 1'b0;
            size_q  <= 2'b00;
            addr_q  <= '0;
            wdata_q <= '0;
`ifdef ARB_RR_EN
            last_grant <= 1'b0;
`endif
        end else begin
            state   <= state_nxt;
            owner   <= owner_nxt;
            req_q   <= req_nxt;
            wr_q    <= wr_nxt;
            size_q  <= size_nxt;
            addr_q  <= addr_nxt;
            wdata_q <= wdata_nxt;
`ifdef ARB_RR_EN
            last_grant <= last_grant_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        req_nxt   = req_q;
        wr_nxt    = wr_q;
        size_nxt  = size_q;
        addr_nxt  = addr_q;
        wdata_nxt = wdata_q;
`ifdef ARB_RR_EN
        last_grant_nxt = last_grant;
`endif
        case (state)
            IDLE: begin
                if (inst_req || data_req) begin
                    state_nxt = ADDR;
                    owner_nxt = grant_data;
                    req_nxt   = 1'b1;
`ifdef ARB_RR_EN
                    last_grant_nxt = grant_data;
`endif
                    if (grant_data) begin
                        wr_nxt    = data_wr;
                        size_nxt  = data_size;
                        addr_nxt  = data_addr;
                        wdata_nxt = data_wdata;
                    end else begin
                        wr_nxt    = 1'b0;
                        size_nxt  = 2'b10;
                        addr_nxt  = inst_addr;
                        wdata_nxt = '0;
                    end
                end
            end
            ADDR: begin
                if (addr_ok) begin
                    req_nxt   = 1'b0;
                    state_nxt = data_ok ? IDLE : DATA;
                end
            end
            DATA: begin
                if (data_ok) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                req_nxt   = 1'b0;
            end
        endcase
    end

    // Handshakes are gated by resetn so nothing leaks out while reset is held mid-transaction
    assign addr_hit = resetn && (state == ADDR) && addr_ok;
    assign done_hit = resetn && (((state == ADDR) && addr_ok && data_ok) ||
                                 ((state == DATA) && data_ok));

    assign inst_addr_ok = addr_hit && !owner;
    assign data_addr_ok = addr_hit && owner;
    assign inst_data_ok = done_hit && !owner;
    assign data_data_ok = done_hit && owner;
    assign inst_rdata   = rdata;
    assign data_rdata   = rdata;

    assign req   = req_q;
    assign wr    = wr_q;
    assign size  = size_q;
    assign addr  = addr_q;
    assign wdata = wdata_q;

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed bench for sram_like_arbiter: reset, latencies, arbitration order, store fields, reset abort.
module tb_sram_like_arbiter;

    logic        clk;
    logic        resetn;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    int passes = 0;
    int total  = 0;

    sram_like_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .req          (req),
        .wr           (wr),
        .size         (size),
        .addr         (addr),
        .wdata        (wdata),
        .addr_ok      (addr_ok),
        .data_ok      (data_ok),
        .rdata        (rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish within the time limit");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passes++;
        else begin
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
            $error("%s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are checked 1 unit later still.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_oks(input string tag, input logic ia, input logic id,
                           input logic da, input logic dd);
        chk({tag, ".inst_addr_ok"}, 64'(inst_addr_ok), 64'(ia));
        chk({tag, ".inst_data_ok"}, 64'(inst_data_ok), 64'(id));
        chk({tag, ".data_addr_ok"}, 64'(data_addr_ok), 64'(da));
        chk({tag, ".data_data_ok"}, 64'(data_data_ok), 64'(dd));
    endtask

    // Called in an IDLE cycle with requests set; completes one zero-wait transaction.
    task automatic grant_zero(input string tag, input logic exp_data, input logic [31:0] exp_addr);
        tick();
        addr_ok = 1'b1;
        data_ok = 1'b1;
        rdata   = 32'h0BAD_F00D;
        #1;
        chk({tag, ".req"}, 64'(req), 64'd1);
        chk({tag, ".addr"}, 64'(addr), 64'(exp_addr));
        chk_oks(tag, !exp_data, !exp_data, exp_data, exp_data);
        if (exp_data) data_req = 1'b0;
        else          inst_req = 1'b0;
        tick();
        addr_ok = 1'b0;
        data_ok = 1'b0;
        #1;
        chk({tag, ".idle_req"}, 64'(req), 64'd0);
        chk_oks({tag, ".idle"}, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        resetn     = 1'b0;
        inst_req   = 1'b0;
        inst_addr  = 32'h0;
        data_req   = 1'b0;
        data_wr    = 1'b0;
        data_size  = 2'b00;
        data_addr  = 32'h0;
        data_wdata = 32'h0;
        addr_ok    = 1'b1;
        data_ok    = 1'b1;
        rdata      = 32'h0;

        // Reset held two edges, port handshakes deliberately high
        tick();
        tick();
        #1;
        chk("rst.req", 64'(req), 64'd0);
        chk("rst.addr", 64'(addr), 64'd0);
        chk_oks("rst", 1'b0, 1'b0, 1'b0, 1'b0);
        resetn  = 1'b1;
        addr_ok = 1'b0;
        data_ok = 1'b0;
        tick();

        // Instruction fetch: addr_ok in second ADDR cycle, data_ok three cycles later
        inst_req  = 1'b1;
        inst_addr = 32'hBFC0_0000;
        #1;
        chk("if.req_latency", 64'(req), 64'd0);
        tick();
        chk("if.req", 64'(req), 64'd1);
        chk("if.addr", 64'(addr), 64'hBFC0_0000);
        chk("if.size", 64'(size), 64'd2);
        chk("if.wr", 64'(wr), 64'd0);
        chk_oks("if.wait", 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        addr_ok = 1'b1;
        #1;
        chk_oks("if.aok", 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        addr_ok  = 1'b0;
        inst_req = 1'b0;
        #1;
        chk("if.data_req", 64'(req), 64'd0);
        chk_oks("if.d1", 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        chk_oks("if.d2", 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        data_ok = 1'b1;
        rdata   = 32'h2408_0001;
        #1;
        chk_oks("if.dok", 1'b0, 1'b1, 1'b0, 1'b0);
        chk("if.rdata", 64'(inst_rdata), 64'h2408_0001);
        tick();
        data_ok = 1'b0;
        #1;
        chk_oks("if.after", 1'b0, 1'b0, 1'b0, 1'b0);

        // Simultaneous requests, two rounds, zero-wait port
        inst_req   = 1'b1;
        inst_addr  = 32'h0000_0200;
        data_req   = 1'b1;
        data_addr  = 32'h0000_0100;
        data_size  = 2'b10;
        grant_zero("arb1.data", 1'b1, 32'h0000_0100);
        grant_zero("arb1.inst", 1'b0, 32'h0000_0200);
        inst_req = 1'b1;
        data_req = 1'b1;
        grant_zero("arb2.data", 1'b1, 32'h0000_0100);
        grant_zero("arb2.inst", 1'b0, 32'h0000_0200);

        // Store; an early data_ok in ADDR must be ignored
        data_req   = 1'b1;
        data_wr    = 1'b1;
        data_size  = 2'b01;
        data_addr  = 32'h0000_0002;
        data_wdata = 32'hBEEF_BEEF;
        tick();
        data_ok = 1'b1;
        #1;
        chk("st.req", 64'(req), 64'd1);
        chk("st.wr", 64'(wr), 64'd1);
        chk("st.size", 64'(size), 64'd1);
        chk("st.addr", 64'(addr), 64'h0000_0002);
        chk("st.wdata", 64'(wdata), 64'hBEEF_BEEF);
        chk_oks("st.early_dok", 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        data_ok = 1'b0;
        addr_ok = 1'b1;
        #1;
        chk("st.wdata_hold", 64'(wdata), 64'hBEEF_BEEF);
        chk_oks("st.aok", 1'b0, 1'b0, 1'b1, 1'b0);
        data_req = 1'b0;
        tick();
        addr_ok = 1'b0;
        data_ok = 1'b1;
        #1;
        chk("st.data_req", 64'(req), 64'd0);
        chk_oks("st.dok", 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        addr_ok = 1'b1;
        #1;
        chk_oks("idle.stray", 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        addr_ok = 1'b0;
        data_ok = 1'b0;

        // Reset while in DATA, then a stray data_ok two cycles later
        inst_req  = 1'b1;
        inst_addr = 32'h0000_0300;
        tick();
        addr_ok = 1'b1;
        #1;
        chk_oks("ab.aok", 1'b1, 1'b0, 1'b0, 1'b0);
        inst_req = 1'b0;
        tick();
        addr_ok = 1'b0;
        resetn  = 1'b0;
        data_ok = 1'b1;
        #1;
        chk_oks("ab.in_rst", 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        resetn  = 1'b1;
        data_ok = 1'b0;
        #1;
        chk("ab.req", 64'(req), 64'd0);
        chk("ab.addr", 64'(addr), 64'd0);
        tick();
        data_ok = 1'b1;
        rdata   = 32'h1234_5678;
        #1;
        chk_oks("ab.stray", 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        data_ok = 1'b0;

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
